bram_port_arbiter: RTL
======================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, BRAM word-address width.
REQ-002 Parameter MAX_BURST, default 8, maximum consecutive locked grants to one requester, range 2..255.
REQ-003 HCLK  input  1  single clock; all state on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 mN_req  input  1  requester N (N=0,1) transaction request, one beat per cycle.
REQ-006 mN_lock  input  1  requester N asks to keep ownership for a burst.
REQ-007 mN_we  input  4  byte write strobes; 4'b0000 = read.
REQ-008 mN_addr  input  ADDR_W  word address.
REQ-009 mN_wdata  input  32  write data.
REQ-010 mN_gnt  output  1  beat accepted this cycle (combinational).
REQ-011 mN_rvalid  output  1  read data valid for requester N.
REQ-012 mN_rdata  output  32  read data, equal to bram_rdata.
REQ-013 bram_wraddr, bram_rdaddr  output  ADDR_W each  BRAM write/read port addresses.
REQ-014 bram_wdata  output  32  BRAM write data.
REQ-015 bram_write  output  4  BRAM byte write enables.
REQ-016 bram_rdata  input  32  BRAM read data, valid one cycle after bram_rdaddr is presented.

Function
REQ-017 At most one of m0_gnt/m1_gnt SHALL be high in any cycle; a grant SHALL be issued only to a requester with req=1.
REQ-018 Internal state: last (1 bit, last granted requester), locked (1 bit), owner (1 bit), beat_cnt (8 bits).
REQ-019 Priority 1: if locked=1, mowner_req=1 and beat_cnt<MAX_BURST, the owner SHALL be granted regardless of the other request.
REQ-020 Priority 2: otherwise, if both req=1, the requester !last SHALL be granted (round-robin).
REQ-021 Priority 3: otherwise, the single requesting master SHALL be granted; with no request, no grant.
REQ-022 On a grant to g: last<=g, owner<=g.
REQ-023 Granted with mg_lock=1: if locked=1, owner==g and beat_cnt<MAX_BURST, beat_cnt<=beat_cnt+1; else beat_cnt<=1; locked<=1.
REQ-024 Granted with mg_lock=0: locked<=0, beat_cnt<=0.
REQ-025 Cycle with no grant: locked<=0, beat_cnt<=0 (burst broken by owner deasserting req).
REQ-026 beat_cnt SHALL never exceed MAX_BURST; no wrap-around.
REQ-027 Granted write (we!=0): bram_wraddr=addr, bram_wdata=wdata, bram_write=we, same cycle.
REQ-028 Granted read (we==0): bram_rdaddr=addr, bram_write=0.
REQ-029 No grant: bram_write=0; bram_wraddr, bram_rdaddr, bram_wdata SHALL be 0.
REQ-030 mN_rvalid SHALL be registered: high the cycle after a granted read by N, else low; read latency is exactly 1 cycle.
REQ-031 Back-to-back reads, including alternating requesters, SHALL each produce rvalid in consecutive cycles, no bubble.
REQ-032 A write and a read to the same address in consecutive cycles SHALL be issued in grant order; returned data follows BRAM behaviour.
REQ-033 Request inputs SHALL not be registered; the requester holds req/addr/we/wdata until it sees gnt.

Reset
REQ-034 HRESETn low SHALL asynchronously set last=1, owner=0, locked=0, beat_cnt=0 and m0_rvalid=m1_rvalid=0, so m0 wins the first tie.
REQ-035 During reset, bram_write SHALL be 0; a read granted in the cycle reset asserts SHALL NOT produce rvalid after release.
REQ-036 Reset deassertion SHALL need no recovery cycles; first arbitration occurs in the first clock after release.

Verification
REQ-037 After reset, both req, reads at 0x010/0x020 held 4 cycles -> gnt order m0,m1,m0,m1; rvalid one cycle after each grant, rdata equals preloaded words.
REQ-038 m0 req+lock continuous, m1 req continuous, MAX_BURST=8 -> m0 granted 8 cycles, m1 cycle 9, m0 locked again from cycle 10 with beat_cnt=1.
REQ-039 m0 locked burst, m0_req drops after 3 beats while m1 requests -> m1 granted next cycle, locked=0.
REQ-040 m1 write we=4'b0011 data 0xAABBCCDD addr 0x005, then m0 read 0x005 -> bram_write=0011 for one cycle; m0_rdata low half 0xCCDD.
REQ-041 Only m1 locked, MAX_BURST reached, m0 idle -> m1 keeps grant, beat_cnt restarts at 1, never exceeds 8.
REQ-042 Assert HRESETn low in the same cycle as a granted read -> rvalid stays 0, bram_write 0, first tie after release goes to m0.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Two-requester BRAM port bundle: requester-side handshake signals plus the BRAM-side ports.
// The slave modport is the arbiter's view; the master modport is the requesters/BRAM side.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              m0_req;
  logic              m0_lock;
  logic [3:0]        m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic              m1_lock;
  logic [3:0]        m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [31:0]       m1_rdata;

  logic [ADDR_W-1:0] bram_wraddr;
  logic [ADDR_W-1:0] bram_rdaddr;
  logic [31:0]       bram_wdata;
  logic [3:0]        bram_write;
  logic [31:0]       bram_rdata;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    input  bram_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output bram_wraddr, bram_rdaddr, bram_wdata, bram_write
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
    output bram_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  bram_wraddr, bram_rdaddr, bram_wdata, bram_write
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Arbitrates two requesters onto one BRAM write/read port pair: locked bursts capped at
// MAX_BURST beats, round-robin on ties, single-cycle read latency with registered rvalid.
module bram_port_arbiter #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MAX_BURST = 8
) (
  input logic              HCLK,
  input logic              HRESETn,
  bram_port_arbiter_if.slave bus
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  logic       r_last;
  logic       r_owner;
  logic       r_locked;
  logic [7:0] r_beat_cnt;
  logic       r_rvalid0;
  logic       r_rvalid1;

  logic       w_last_d;
  logic       w_owner_d;
  logic       w_locked_d;
  logic [7:0] w_beat_cnt_d;

  logic              w_owner_req;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic              w_sel;
  logic              w_lock;
  logic [3:0]        w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_is_wr;

  // Grant decision; suppressed while reset is held so nothing reaches the BRAM.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_req = r_owner ? bus.m1_req : bus.m0_req;
    if (HRESETn) begin
      if (r_locked && w_owner_req && (r_beat_cnt < MaxBurst)) begin
        if (r_owner) w_gnt1 = 1'b1;
        else         w_gnt0 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
        if (r_last) w_gnt0 = 1'b1;
        else        w_gnt1 = 1'b1;
      end else if (bus.m0_req) begin
        w_gnt0 = 1'b1;
      end else if (bus.m1_req) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    w_any   = w_gnt0 | w_gnt1;
    w_sel   = w_gnt1;
    w_lock  = w_sel ? bus.m1_lock  : bus.m0_lock;
    w_we    = w_sel ? bus.m1_we    : bus.m0_we;
    w_addr  = w_sel ? bus.m1_addr  : bus.m0_addr;
    w_wdata = w_sel ? bus.m1_wdata : bus.m0_wdata;
    w_is_wr = (w_we != 4'b0000);
  end

  always_comb begin
    w_last_d     = r_last;
    w_owner_d    = r_owner;
    w_locked_d   = 1'b0;
    w_beat_cnt_d = 8'd0;
    if (w_any) begin
      w_last_d  = w_sel;
      w_owner_d = w_sel;
      if (w_lock) begin
        w_locked_d = 1'b1;
        // Continuing an unfinished burst counts up; anything else starts a fresh one.
        if (r_locked && (r_owner == w_sel) && (r_beat_cnt < MaxBurst)) begin
          w_beat_cnt_d = r_beat_cnt + 8'd1;
        end else begin
          w_beat_cnt_d = 8'd1;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_locked   <= 1'b0;
      r_beat_cnt <= 8'd0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_last     <= w_last_d;
      r_owner    <= w_owner_d;
      r_locked   <= w_locked_d;
      r_beat_cnt <= w_beat_cnt_d;
      r_rvalid0  <= w_gnt0 && (bus.m0_we == 4'b0000);
      r_rvalid1  <= w_gnt1 && (bus.m1_we == 4'b0000);
    end
  end

  always_comb begin
    bus.m0_gnt      = w_gnt0;
    bus.m1_gnt      = w_gnt1;
    bus.m0_rvalid   = r_rvalid0;
    bus.m1_rvalid   = r_rvalid1;
    bus.m0_rdata    = bus.bram_rdata;
    bus.m1_rdata    = bus.bram_rdata;
    bus.bram_write  = w_any ? w_we : 4'b0000;
    bus.bram_wraddr = (w_any && w_is_wr) ? w_addr : '0;
    bus.bram_wdata  = (w_any && w_is_wr) ? w_wdata : 32'd0;
    bus.bram_rdaddr = (w_any && !w_is_wr) ? w_addr : '0;
  end

endmodule
